// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared Y86-64 encodings and pipeline-control state for the hazard control unit.
package pipeline_hazard_ctrl_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] S_BUB = 3'd0;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_ADR = 3'd2;
  localparam logic [2:0] S_INS = 3'd3;
  localparam logic [2:0] S_HLT = 3'd4;

  typedef enum logic [1:0] {
    PCS_RUN      = 2'd0,
    PCS_MEM_WAIT = 2'd1,
    PCS_HALTED   = 2'd2
  } pcs_e;

  // Bubble and AOK are both normal flow; only real faults drain the pipe.
  function automatic logic is_exception(input logic [2:0] stat);
    return (stat == S_ADR) || (stat == S_INS) || (stat == S_HLT);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-status inputs and stall/bubble/counter outputs of the hazard control unit.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       D_icode_i;
  logic [3:0]       d_srcA_i;
  logic [3:0]       d_srcB_i;
  logic [3:0]       E_icode_i;
  logic [3:0]       E_dstM_i;
  logic             e_Cnd_i;
  logic [3:0]       M_icode_i;
  logic [2:0]       m_stat_i;
  logic [2:0]       W_stat_i;
  logic             dmem_ready_i;
  logic             perf_clr_i;

  logic             F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o;
  logic             D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o;
  logic             set_cc_o;
  logic             halted_o;
  logic             mem_timeout_o;
  logic [CNT_W-1:0] cnt_loaduse_o, cnt_mispred_o, cnt_ret_o, cnt_memwait_o;

  modport master (
    output D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_Cnd_i,
           M_icode_i, m_stat_i, W_stat_i, dmem_ready_i, perf_clr_i,
    input  F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
           D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o,
           set_cc_o, halted_o, mem_timeout_o,
           cnt_loaduse_o, cnt_mispred_o, cnt_ret_o, cnt_memwait_o
  );

  modport slave (
    input  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_Cnd_i,
           M_icode_i, m_stat_i, W_stat_i, dmem_ready_i, perf_clr_i,
    output F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
           D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o,
           set_cc_o, halted_o, mem_timeout_o,
           cnt_loaduse_o, cnt_mispred_o, cnt_ret_o, cnt_memwait_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with a clear that wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt_o <= '0;
    else if (clr_i)                   cnt_o <= '0;
    else if (inc_i && (cnt_o != '1))  cnt_o <= cnt_o + W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, sticky halt, memory-wait timeout, perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int WAIT_TIMEOUT = 256,
  parameter int WAIT_W       = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(WAIT_TIMEOUT);

  pcs_e              state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   wait_inc;
  logic              lu, mp, rt, mw, exm, exw, halted, timeout_hit;

  assign lu = ((hz.E_icode_i == I_MRMOVQ) || (hz.E_icode_i == I_POPQ)) &&
              (hz.E_dstM_i != RNONE) &&
              ((hz.E_dstM_i == hz.d_srcA_i) || (hz.E_dstM_i == hz.d_srcB_i));
  assign mp = (hz.E_icode_i == I_JXX) && !hz.e_Cnd_i;
  assign rt = (hz.D_icode_i == I_RET) || (hz.E_icode_i == I_RET) || (hz.M_icode_i == I_RET);
  assign mw = ((hz.M_icode_i == I_RMMOVQ) || (hz.M_icode_i == I_MRMOVQ) ||
               (hz.M_icode_i == I_CALL)   || (hz.M_icode_i == I_RET)    ||
               (hz.M_icode_i == I_PUSHQ)  || (hz.M_icode_i == I_POPQ)) && !hz.dmem_ready_i;
  assign exm = is_exception(hz.m_stat_i);
  assign exw = is_exception(hz.W_stat_i);

  assign halted      = (state == PCS_HALTED);
  assign wait_inc    = {1'b0, wait_cnt} + (WAIT_W + 1)'(1);
  assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_inc >= TIMEOUT_V);

  assign hz.halted_o = halted;

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    hz.F_stall_o  = 1'b0;
    hz.D_stall_o  = 1'b0;
    hz.E_stall_o  = 1'b0;
    hz.M_stall_o  = 1'b0;
    hz.W_stall_o  = 1'b0;
    hz.D_bubble_o = 1'b0;
    hz.E_bubble_o = 1'b0;
    hz.M_bubble_o = 1'b0;
    hz.W_bubble_o = 1'b0;
    hz.set_cc_o   = 1'b0;
    if (!rst_n) begin
      // Keep every stage quiet while reset is asserted.
    end else if (halted) begin
      hz.F_stall_o  = 1'b1;
      hz.D_stall_o  = 1'b1;
      hz.W_stall_o  = 1'b1;
      hz.E_bubble_o = 1'b1;
      hz.M_bubble_o = 1'b1;
    end else if (mw) begin
      // A faulting Writeback turns the M/W freeze into drain-and-hold.
      hz.F_stall_o  = 1'b1;
      hz.D_stall_o  = 1'b1;
      hz.E_stall_o  = 1'b1;
      hz.M_stall_o  = !exw;
      hz.W_bubble_o = !exw;
      hz.W_stall_o  = exw;
      hz.M_bubble_o = exw;
    end else begin
      hz.F_stall_o  = lu | rt;
      hz.D_stall_o  = lu;
      hz.D_bubble_o = mp | (rt & !lu);
      hz.E_bubble_o = mp | lu;
      hz.M_bubble_o = exm | exw;
      hz.W_stall_o  = exw;
      hz.set_cc_o   = (hz.E_icode_i == I_OPQ) && !exm && !exw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= PCS_RUN;
      wait_cnt         <= '0;
      hz.mem_timeout_o <= 1'b0;
    end else begin
      case (state)
        PCS_RUN: begin
          if (exw) begin
            state <= PCS_HALTED;
          end else if (mw) begin
            state    <= PCS_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        PCS_MEM_WAIT: begin
          if (mw) begin
            wait_cnt <= wait_inc[WAIT_W-1:0];
            if (timeout_hit) begin
              state            <= PCS_HALTED;
              hz.mem_timeout_o <= 1'b1;
            end
          end else begin
            state    <= PCS_RUN;
            wait_cnt <= '0;
          end
          if (exw) state <= PCS_HALTED;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_loaduse (
    .clk(clk), .rst_n(rst_n), .clr_i(hz.perf_clr_i),
    .inc_i(lu && !mw && !halted), .cnt_o(hz.cnt_loaduse_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mispred (
    .clk(clk), .rst_n(rst_n), .clr_i(hz.perf_clr_i),
    .inc_i(mp && !mw && !halted), .cnt_o(hz.cnt_mispred_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_ret (
    .clk(clk), .rst_n(rst_n), .clr_i(hz.perf_clr_i),
    .inc_i(rt && !lu && !mw && !halted), .cnt_o(hz.cnt_ret_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_memwait (
    .clk(clk), .rst_n(rst_n), .clr_i(hz.perf_clr_i),
    .inc_i(mw && !halted), .cnt_o(hz.cnt_memwait_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with 4-bit counters and a 4-cycle memory-wait timeout.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(4)) hz ();

  pipeline_hazard_ctrl #(
    .CNT_W(4), .WAIT_TIMEOUT(4), .WAIT_W(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // {F,D,E,M,W stall | D,E,M,W bubble | set_cc, halted}
  logic [10:0] ctl;
  assign ctl = {hz.F_stall_o, hz.D_stall_o, hz.E_stall_o, hz.M_stall_o, hz.W_stall_o,
                hz.D_bubble_o, hz.E_bubble_o, hz.M_bubble_o, hz.W_bubble_o,
                hz.set_cc_o, hz.halted_o};

  logic [10:0] exp_ctl;
  logic [3:0]  exp_cnt;

  task automatic idle();
    hz.D_icode_i    = I_NOP;
    hz.d_srcA_i     = RNONE;
    hz.d_srcB_i     = RNONE;
    hz.E_icode_i    = I_NOP;
    hz.E_dstM_i     = RNONE;
    hz.e_Cnd_i      = 1'b1;
    hz.M_icode_i    = I_NOP;
    hz.m_stat_i     = S_AOK;
    hz.W_stat_i     = S_AOK;
    hz.dmem_ready_i = 1'b1;
    hz.perf_clr_i   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    hz.E_icode_i = I_OPQ;
    hz.W_stat_i  = S_ADR;
    #2;
    checks++;
    if (ctl !== 11'b0) begin
      errors++; $display("FAIL reset_ctl: got=%b want=%b", ctl, 11'b0);
    end
    tick();
    checks++;
    if ({hz.cnt_loaduse_o, hz.cnt_mispred_o, hz.cnt_ret_o, hz.cnt_memwait_o, hz.mem_timeout_o, hz.halted_o} !== 18'b0) begin
      errors++; $display("FAIL reset_state: cnts=%h/%h/%h/%h timeout=%b halted=%b want all 0",
                         hz.cnt_loaduse_o, hz.cnt_mispred_o, hz.cnt_ret_o, hz.cnt_memwait_o, hz.mem_timeout_o, hz.halted_o);
    end
    idle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctl !== 11'b0) begin
      errors++; $display("FAIL idle_after_reset: got=%b want=%b", ctl, 11'b0);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    hz.E_icode_i = I_MRMOVQ; hz.E_dstM_i = 4'd3; hz.d_srcA_i = 4'd3;
    #1;
    exp_ctl = 11'b11000_0100_00;
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL lu_srcA_ctl: got=%b want=%b", ctl, exp_ctl);
    end
    tick();
    checks++;
    if (hz.cnt_loaduse_o !== 4'd1) begin
      errors++; $display("FAIL lu_count: got=%0d want=1", hz.cnt_loaduse_o);
    end
    hz.E_dstM_i = RNONE; hz.d_srcA_i = RNONE; hz.d_srcB_i = RNONE;
    #1;
    checks++;
    if (ctl !== 11'b0) begin
      errors++; $display("FAIL lu_rnone_ctl: got=%b want=%b", ctl, 11'b0);
    end
    tick();
    hz.E_icode_i = I_POPQ; hz.E_dstM_i = 4'd5; hz.d_srcB_i = 4'd5;
    #1;
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL lu_popq_srcB_ctl: got=%b want=%b", ctl, exp_ctl);
    end
    tick();
    checks++;
    if (hz.cnt_loaduse_o !== 4'd2) begin
      errors++; $display("FAIL lu_count2: got=%0d want=2", hz.cnt_loaduse_o);
    end
  endtask

  task automatic test_ret_mispredict();
    apply_reset();
    hz.D_icode_i = I_RET;
    hz.E_icode_i = I_MRMOVQ; hz.E_dstM_i = 4'd3; hz.d_srcA_i = 4'd3;
    #1;
    exp_ctl = 11'b11000_0100_00;
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL lu_ret_ctl: got=%b want=%b", ctl, exp_ctl);
    end
    tick();
    checks++;
    if ({hz.cnt_ret_o, hz.cnt_loaduse_o} !== {4'd0, 4'd1}) begin
      errors++; $display("FAIL lu_ret_counts: ret=%0d lu=%0d want ret=0 lu=1", hz.cnt_ret_o, hz.cnt_loaduse_o);
    end
    idle();
    hz.E_icode_i = I_JXX; hz.e_Cnd_i = 1'b0; hz.M_icode_i = I_RET;
    #1;
    exp_ctl = 11'b10000_1100_00;
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL mp_ret_ctl: got=%b want=%b", ctl, exp_ctl);
    end
    tick();
    checks++;
    if ({hz.cnt_mispred_o, hz.cnt_ret_o} !== {4'd1, 4'd1}) begin
      errors++; $display("FAIL mp_ret_counts: mp=%0d ret=%0d want mp=1 ret=1", hz.cnt_mispred_o, hz.cnt_ret_o);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    hz.M_icode_i = I_MRMOVQ; hz.dmem_ready_i = 1'b0; hz.E_icode_i = I_OPQ;
    exp_ctl = 11'b11110_0001_00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== exp_ctl) begin
        errors++; $display("FAIL mw_ctl[%0d]: got=%b want=%b", i, ctl, exp_ctl);
      end
      tick();
    end
    checks++;
    if (hz.cnt_memwait_o !== 4'd3) begin
      errors++; $display("FAIL mw_count: got=%0d want=3", hz.cnt_memwait_o);
    end
    hz.dmem_ready_i = 1'b1;
    #1;
    exp_ctl = 11'b00000_0000_10;
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL mw_release_ctl: got=%b want=%b", ctl, exp_ctl);
    end
    tick();
    checks++;
    if ({ctl, hz.cnt_memwait_o} !== {exp_ctl, 4'd3}) begin
      errors++; $display("FAIL mw_run_again: ctl=%b cnt=%0d want ctl=%b cnt=3", ctl, hz.cnt_memwait_o, exp_ctl);
    end
    hz.dmem_ready_i = 1'b0; hz.W_stat_i = S_HLT;
    #1;
    exp_ctl = 11'b11101_0010_00;
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL mw_exw_ctl: got=%b want=%b", ctl, exp_ctl);
    end
    tick();
    checks++;
    if ({hz.halted_o, hz.mem_timeout_o, hz.cnt_memwait_o} !== {1'b1, 1'b0, 4'd4}) begin
      errors++; $display("FAIL mw_exw_halt: halted=%b timeout=%b cnt=%0d want 1 0 4",
                         hz.halted_o, hz.mem_timeout_o, hz.cnt_memwait_o);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    hz.M_icode_i = I_MRMOVQ; hz.dmem_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({hz.halted_o, hz.mem_timeout_o} !== {2{i == 4}}) begin
        errors++; $display("FAIL timeout_edge%0d: halted=%b timeout=%b want %b", i, hz.halted_o, hz.mem_timeout_o, i == 4);
      end
    end
    exp_ctl = 11'b11001_0110_01;
    checks++;
    if ({ctl, hz.cnt_memwait_o} !== {exp_ctl, 4'd4}) begin
      errors++; $display("FAIL timeout_halted_ctl: ctl=%b cnt=%0d want ctl=%b cnt=4", ctl, hz.cnt_memwait_o, exp_ctl);
    end
    hz.dmem_ready_i = 1'b1;
    tick();
    hz.dmem_ready_i = 1'b0;
    tick();
    checks++;
    if ({hz.halted_o, hz.mem_timeout_o, hz.cnt_memwait_o} !== {1'b1, 1'b1, 4'd4}) begin
      errors++; $display("FAIL timeout_sticky: halted=%b timeout=%b cnt=%0d want 1 1 4",
                         hz.halted_o, hz.mem_timeout_o, hz.cnt_memwait_o);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hz.halted_o, hz.mem_timeout_o, ctl} !== 13'b0) begin
      errors++; $display("FAIL timeout_async_reset: halted=%b timeout=%b ctl=%b want all 0",
                         hz.halted_o, hz.mem_timeout_o, ctl);
    end
  endtask

  task automatic test_exception();
    apply_reset();
    hz.E_icode_i = I_OPQ; hz.W_stat_i = S_ADR;
    #1;
    exp_ctl = 11'b00001_0010_00;
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL exw_ctl: got=%b want=%b", ctl, exp_ctl);
    end
    tick();
    hz.W_stat_i = S_AOK;
    #1;
    exp_ctl = 11'b11001_0110_01;
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL exw_halted_ctl: got=%b want=%b", ctl, exp_ctl);
    end
    tick();
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL exw_sticky: got=%b want=%b", ctl, exp_ctl);
    end
    apply_reset();
    hz.E_icode_i = I_OPQ; hz.m_stat_i = S_INS; hz.W_stat_i = S_BUB;
    #1;
    exp_ctl = 11'b00000_0010_00;
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL exm_ctl: got=%b want=%b", ctl, exp_ctl);
    end
    tick();
    checks++;
    if (ctl !== exp_ctl) begin
      errors++; $display("FAIL exm_no_halt: got=%b want=%b", ctl, exp_ctl);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    hz.E_icode_i = I_MRMOVQ; hz.E_dstM_i = 4'd7; hz.d_srcA_i = 4'd7;
    repeat (20) tick();
    checks++;
    if (hz.cnt_loaduse_o !== 4'd15) begin
      errors++; $display("FAIL sat_count: got=%0d want=15", hz.cnt_loaduse_o);
    end
    hz.perf_clr_i = 1'b1;
    tick();
    checks++;
    if (hz.cnt_loaduse_o !== 4'd0) begin
      errors++; $display("FAIL clr_priority: got=%0d want=0", hz.cnt_loaduse_o);
    end
    hz.perf_clr_i = 1'b0;
    tick();
    exp_cnt = 4'd1;
    checks++;
    if (hz.cnt_loaduse_o !== exp_cnt) begin
      errors++; $display("FAIL count_after_clr: got=%0d want=%0d", hz.cnt_loaduse_o, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_ret_mispredict();
    test_mem_wait();
    test_timeout();
    test_exception();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
